controlador_de_interrupcao: RTL
===============================

CONTROLADOR_DE_INTERRUPCAO -- requirements
Module: controlador_de_interrupcao

Interface
REQ-001 Parameter TIMER_QUANTUM, default 1024, is the timer period in clock cycles; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 irqIn  input  4  interrupt sources, rising-edge sensitive: 0 timer, 1 disk done, 2 keyboard input, 3 external I/O.
REQ-005 inta  input  1  one-cycle acknowledge pulse from the control unit (pre_io instruction).
REQ-006 clearIntr  input  1  one-cycle pulse from the control unit (cic instruction) ending service.
REQ-007 userMode  input  1  pulse from the control unit (exec, exec_again): enables interrupts.
REQ-008 kernelMode  input  1  pulse from the control unit (syscall): disables interrupts.
REQ-009 pcIn  input  32  current PC, captured on acknowledge.
REQ-010 intr  output  1  interrupt request to the control unit.
REQ-011 intCode  output  32  active code: 0 = none, otherwise source index + 1 (read by gic).
REQ-012 intPc  output  32  PC captured at acknowledge (read by gip).

Function
REQ-013 Each irqIn bit is registered once and edge-detected; a 0->1 transition sets pending[i] on the next cycle.
REQ-014 A new edge on an already-set pending bit leaves it set; pending does not count occurrences.
REQ-015 Interrupt enable flag: userMode sets it, kernelMode clears it; if both pulse in one cycle, kernelMode wins.
REQ-016 FSM states IDLE, REQ and SERV.
REQ-017 IDLE->REQ when enable=1 and pending!=0.
REQ-018 REQ->SERV on inta.
REQ-019 REQ->IDLE if enable=0 and inta=0.
REQ-020 SERV->IDLE on clearIntr.
REQ-021 intr=1 exactly while in REQ; it is a registered output.
REQ-022 On inta in REQ, the following are updated in the same edge:
  - selected source = lowest set pending index;
  - intCode <= index+1;
  - that pending bit is cleared;
  - intPc <= pcIn.
REQ-023 If a new edge arrives on the selected source in the acknowledge cycle, set wins and the bit stays pending.
REQ-024 On clearIntr in SERV, intCode <= 0; intPc holds its value.
REQ-025 Ignored inputs:
  - clearIntr in IDLE or REQ;
  - inta in IDLE or SERV.
REQ-026 Latency: from an irqIn edge to intr=1 is 3 cycles when enabled and idle (sync, pending, REQ).
REQ-027 Pending sources accumulate during SERV; they are taken in priority order after clearIntr returns to IDLE.

Reset
REQ-028 On rst, all of the following return to zero or their idle value on the next edge:
  - state=IDLE;
  - pending=0, enable=0;
  - intr=0, intCode=0, intPc=0;
  - edge-detector registers=0;
  - timer counter=0.
REQ-029 rst asserted in REQ or SERV aborts service; an in-flight interrupt is lost.

Configuration
REQ-030 With INTR_TIMER_EN defined, source 0 comes from an internal quantum counter and irqIn[0] is ignored.
REQ-031 The counter runs only while enable=1, clears when enable=0, and pulses at TIMER_QUANTUM-1, then wraps to 0.
REQ-032 Without INTR_TIMER_EN, no counter exists and source 0 is the external irqIn[0].

Structure
REQ-033 Shared package intr_pkg holds:
  - the FSM state enum;
  - constants INT_NONE=0, INT_TIMER=1, INT_DISK=2, INT_INPUT=3, INT_IO=4;
  - source count 4.
REQ-034 One sub-module, temporizador_quantum, implements the counter of REQ-031; it is instantiated only under INTR_TIMER_EN.

Verification
REQ-035 Directed scenarios the bench shall cover:
  - Enable, pulse irqIn[1], pcIn=0x40 -> intr=1 after 3 cycles; after inta, intCode=2 and intPc=0x40; after clearIntr, intCode=0.
  - irqIn[2] and irqIn[3] edges in the same cycle -> first service intCode=3; after clearIntr, second service intCode=4.
  - Interrupts disabled, pulse irqIn[1] -> intr stays 0; userMode pulse -> intr=1 within 1 cycle.
  - In REQ, pulse kernelMode -> back to IDLE with intr=0; a later userMode pulse re-requests with the same code.
  - rst during SERV with intCode=2 -> intCode=0, intr=0, pending=0 on the next edge.
  - INTR_TIMER_EN with TIMER_QUANTUM=8, enabled -> intr rises after the 8-cycle period plus pipeline latency; intCode=1 after inta.

Source files
------------

// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intr_pkg
//  Description : Shared types and constants for the interrupt controller:
//                FSM state encoding, interrupt code values, source count and
//                the fixed-priority selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

  localparam int SRC_COUNT = 4;

  // Codes presented on intCode: 0 means nothing in service, else index + 1.
  localparam logic [31:0] INT_NONE  = 32'd0;
  localparam logic [31:0] INT_TIMER = 32'd1;
  localparam logic [31:0] INT_DISK  = 32'd2;
  localparam logic [31:0] INT_INPUT = 32'd3;
  localparam logic [31:0] INT_IO    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  // Lowest set index wins; scanning downwards lets the lowest bit overwrite.
  function automatic logic [1:0] lowest_index(input logic [SRC_COUNT-1:0] p);
    logic [1:0] idx;
    idx = '0;
    for (int i = SRC_COUNT - 1; i >= 0; i--) begin
      if (p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_de_interrupcao_if.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_de_interrupcao_if
//  Description : Signal bundle between the control unit (master) and the
//                interrupt controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface controlador_de_interrupcao_if;

  logic [3:0]  irqIn;
  logic        inta;
  logic        clearIntr;
  logic        userMode;
  logic        kernelMode;
  logic [31:0] pcIn;
  logic        intr;
  logic [31:0] intCode;
  logic [31:0] intPc;

  modport master (
    output irqIn, inta, clearIntr, userMode, kernelMode, pcIn,
    input  intr, intCode, intPc
  );

  modport slave (
    input  irqIn, inta, clearIntr, userMode, kernelMode, pcIn,
    output intr, intCode, intPc
  );

endinterface
`default_nettype wire

// File: rtl/temporizador_quantum.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_quantum
//  Description : Quantum timer. Counts while enabled, clears while disabled,
//                pulses tick when the count reaches TIMER_QUANTUM-1 and wraps.
//                Only present when INTR_TIMER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef INTR_TIMER_EN
import intr_pkg::*;

module temporizador_quantum #(
  parameter int TIMER_QUANTUM = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] C_LAST = 16'(TIMER_QUANTUM - 1);

  logic [15:0] count_q, count_d;

  // Next count and terminal-count pulse.
  always_comb begin
    tick    = enable && (count_q == C_LAST);
    count_d = '0;
    if (enable && !tick) count_d = count_q + 16'd1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule
`endif
`default_nettype wire

// File: rtl/controlador_de_interrupcao.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_de_interrupcao
//  Description : Four-source edge-triggered interrupt controller with fixed
//                priority (lowest index first), enable flag and a
//                request/acknowledge/clear handshake with the control unit.
//                Optional macro INTR_TIMER_EN replaces source 0 with the
//                internal quantum timer.
//  Revision    : 1.0 - initial release
// ============================================================================
import intr_pkg::*;

module controlador_de_interrupcao #(
  parameter int TIMER_QUANTUM = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  controlador_de_interrupcao_if.slave  bus
);

  if (TIMER_QUANTUM < 2 || TIMER_QUANTUM > 65535) begin : g_quantum_range_err
    $error("TIMER_QUANTUM out of range 2..65535");
  end

  logic [SRC_COUNT-1:0] irq_src;
  logic [SRC_COUNT-1:0] sync_q, sync_d, dly_q, dly_d, edge_vec;
  logic [SRC_COUNT-1:0] pending_q, pending_d, clr_mask;
  logic                 enable_q, enable_d;
  state_t               state_q, state_d;
  logic                 intr_q, intr_d;
  logic [31:0]          int_code_q, int_code_d;
  logic [31:0]          int_pc_q, int_pc_d;
  logic [1:0]           sel_idx;

`ifdef INTR_TIMER_EN
  logic timer_tick;
  logic unused_irq0;

  temporizador_quantum #(
    .TIMER_QUANTUM (TIMER_QUANTUM)
  ) u_temporizador_quantum (
    .clk    (clk),
    .rst    (rst),
    .enable (enable_q),
    .tick   (timer_tick)
  );

  assign irq_src     = {bus.irqIn[3:1], timer_tick};
  assign unused_irq0 = bus.irqIn[0];
`else
  assign irq_src = bus.irqIn;
`endif

  // Edge detection, enable flag, pending set/clear and the request FSM.
  always_comb begin
    sync_d   = irq_src;
    dly_d    = sync_q;
    edge_vec = sync_q & ~dly_q;

    // Kernel mode has the last word when both pulses coincide.
    enable_d = enable_q;
    if (bus.userMode)   enable_d = 1'b1;
    if (bus.kernelMode) enable_d = 1'b0;

    state_d    = state_q;
    clr_mask   = '0;
    sel_idx    = lowest_index(pending_q);
    int_code_d = int_code_q;
    int_pc_d   = int_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_d && (pending_q != '0)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.inta) begin
          state_d           = ST_SERV;
          clr_mask[sel_idx] = 1'b1;
          int_code_d        = INT_TIMER + 32'(sel_idx);
          int_pc_d          = bus.pcIn;
        end else if (!enable_d) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (bus.clearIntr) begin
          state_d    = ST_IDLE;
          int_code_d = INT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh edge in the acknowledge cycle re-arms the bit it clears.
    pending_d = (pending_q & ~clr_mask) | edge_vec;
    intr_d    = (state_d == ST_REQ);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      dly_q      <= '0;
      pending_q  <= '0;
      enable_q   <= 1'b0;
      state_q    <= ST_IDLE;
      intr_q     <= 1'b0;
      int_code_q <= INT_NONE;
      int_pc_q   <= '0;
    end else begin
      sync_q     <= sync_d;
      dly_q      <= dly_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      intr_q     <= intr_d;
      int_code_q <= int_code_d;
      int_pc_q   <= int_pc_d;
    end
  end

  assign bus.intr    = intr_q;
  assign bus.intCode = int_code_q;
  assign bus.intPc   = int_pc_q;

endmodule
`default_nettype wire
